// File: rtl/uart_rx_wb_ctrl.sv
// Wishbone register front-end for a UART receiver: byte FIFO, status/ctrl registers, level irq.
// Optional idle-timeout interrupt is compiled in with `define UART_RX_CTRL_TIMEOUT_EN.
module uart_rx_wb_ctrl #(
  parameter int DEPTH         = 8,
  parameter int TIMEOUT_TICKS = 4096
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_valid,
  input  logic [7:0] rx_data,
  input  logic       wb_stb,
  input  logic       wb_we,
  input  logic [1:0] wb_adr,
  input  logic [7:0] wb_dat_i,
  output logic [7:0] wb_dat_o,
  output logic       wb_ack,
  output logic       irq
);

  localparam int AW = $clog2(DEPTH);
  localparam int LW = AW + 1;

  logic [7:0]    r_mem [DEPTH];
  logic [AW-1:0] r_rd_ptr;
  logic [AW-1:0] r_wr_ptr;
  logic [LW-1:0] r_level;
  logic          r_overrun;
  logic          r_irq_en;
  logic [3:0]    r_thresh;
  logic          r_ack;
  logic [7:0]    r_dat_o;
  logic          r_irq;

  logic       w_acc;
  logic       w_rd;
  logic       w_wr;
  logic       w_pop;
  logic       w_push;
  logic       w_ovr_set;
  logic       w_empty;
  logic       w_full;
  logic [4:0] w_level5;
  logic [7:0] w_rdata;
  logic       w_to_flag;
  logic       w_unused;

  // A strobe is accepted only when no ack is outstanding, so a held strobe acks every other cycle.
  assign w_acc     = wb_stb & ~r_ack;
  assign w_rd      = w_acc & ~wb_we;
  assign w_wr      = w_acc & wb_we;
  assign w_empty   = (r_level == '0);
  assign w_full    = (r_level == LW'(DEPTH));
  assign w_pop     = w_rd & (wb_adr == 2'd0) & ~w_empty;
  assign w_push    = rx_valid & (~w_full | w_pop);
  assign w_ovr_set = rx_valid & ~w_push;
  assign w_level5  = 5'(r_level);
  assign w_unused  = ^wb_dat_i[6:4];

  always_comb begin
    w_rdata = 8'h00;
    case (wb_adr)
      2'd0:    w_rdata = w_empty ? 8'h00 : r_mem[r_rd_ptr];
      2'd1:    w_rdata = {r_overrun, w_full, ~w_empty, w_level5};
      2'd2:    w_rdata = {r_irq_en, 3'b000, r_thresh};
      default: w_rdata = 8'h00;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= rx_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rd_ptr  <= '0;
      r_wr_ptr  <= '0;
      r_level   <= '0;
      r_overrun <= 1'b0;
      r_irq_en  <= 1'b0;
      r_thresh  <= 4'h0;
      r_ack     <= 1'b0;
      r_dat_o   <= 8'h00;
      r_irq     <= 1'b0;
    end else begin
      r_ack   <= w_acc;
      r_dat_o <= w_rd ? w_rdata : 8'h00;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_push & ~w_pop)      r_level <= r_level + 1'b1;
      else if (w_pop & ~w_push) r_level <= r_level - 1'b1;
      // A dropped byte outranks a simultaneous clear request.
      if (w_ovr_set)                      r_overrun <= 1'b1;
      else if (w_wr && wb_adr == 2'd1)    r_overrun <= 1'b0;
      if (w_wr && wb_adr == 2'd2) begin
        r_irq_en <= wb_dat_i[7];
        r_thresh <= wb_dat_i[3:0];
      end
      r_irq <= r_irq_en & ((w_level5 > {1'b0, r_thresh}) | r_overrun | w_to_flag);
    end
  end

`ifdef UART_RX_CTRL_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_TICKS) + 1;
  logic [TW-1:0] r_to_cnt;
  logic          r_to_flag;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_to_cnt  <= '0;
      r_to_flag <= 1'b0;
    end else if (w_pop || w_empty) begin
      r_to_cnt  <= '0;
      r_to_flag <= 1'b0;
    end else if (rx_valid) begin
      r_to_cnt <= '0;
    end else if (r_to_cnt == TW'(TIMEOUT_TICKS - 1)) begin
      r_to_flag <= 1'b1;
    end else begin
      r_to_cnt <= r_to_cnt + 1'b1;
    end
  end

  assign w_to_flag = r_to_flag;
`else
  assign w_to_flag = 1'b0;
`endif

  assign wb_dat_o = r_dat_o;
  assign wb_ack   = r_ack;
  assign irq      = r_irq;

endmodule

// File: tb/tb_uart_rx_wb_ctrl.sv
// Scoreboard bench for uart_rx_wb_ctrl: bus driver queues expected read data, negedge monitor checks acks.
module tb_uart_rx_wb_ctrl;

  localparam int DEPTH = 4;
  localparam int TO    = 16;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       rx_valid = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       wb_stb = 1'b0;
  logic       wb_we = 1'b0;
  logic [1:0] wb_adr = 2'd0;
  logic [7:0] wb_dat_i = 8'h00;
  logic [7:0] wb_dat_o;
  logic       wb_ack;
  logic       irq;

  int tests = 0;
  int fails = 0;

  // Reference model: FIFO as a queue plus the architectural register bits.
  logic [7:0] m_q[$];
  bit         m_ovr = 1'b0;
  bit         m_en = 1'b0;
  logic [3:0] m_thr = 4'h0;
  logic [7:0] exp_q[$];
  int         adr_q[$];

  uart_rx_wb_ctrl #(.DEPTH(DEPTH), .TIMEOUT_TICKS(TO)) dut (
    .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_data(rx_data),
    .wb_stb(wb_stb), .wb_we(wb_we), .wb_adr(wb_adr), .wb_dat_i(wb_dat_i),
    .wb_dat_o(wb_dat_o), .wb_ack(wb_ack), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string nm, input logic [7:0] act, input logic [7:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %02h expected %02h at %0t", nm, act, exp, $time);
    end else begin
      $display("[TB] ok %s = %02h", nm, act);
    end
  endtask

  function automatic logic [7:0] m_status();
    return {m_ovr, m_q.size() == DEPTH, m_q.size() != 0, 5'(m_q.size())};
  endfunction

  function automatic bit m_irq();
    return m_en && ((m_q.size() > int'(m_thr)) || m_ovr);
  endfunction

  function automatic bit irq_predictable();
`ifdef UART_RX_CTRL_TIMEOUT_EN
    return !(m_en && m_q.size() != 0);
`else
    return 1'b1;
`endif
  endfunction

  function automatic void m_rx(input logic [7:0] d);
    if (m_q.size() < DEPTH) m_q.push_back(d);
    else m_ovr = 1'b1;
  endfunction

  task automatic bus(input bit we, input logic [1:0] adr, input logic [7:0] dat,
                     input bit rxv, input logic [7:0] rxd);
    logic [7:0] e;
    bit pop;
    @(posedge clk); #1;
    wb_stb = 1'b1; wb_we = we; wb_adr = adr; wb_dat_i = dat;
    rx_valid = rxv; rx_data = rxd;
    pop = !we && adr == 2'd0 && m_q.size() > 0;
    e = 8'h00;
    if (!we) begin
      case (adr)
        2'd0:    e = pop ? m_q[0] : 8'h00;
        2'd1:    e = m_status();
        2'd2:    e = {m_en, 3'b000, m_thr};
        default: e = 8'h00;
      endcase
    end
    exp_q.push_back(e);
    adr_q.push_back(int'(adr));
    if (pop) void'(m_q.pop_front());
    if (we && adr == 2'd1) m_ovr = 1'b0;
    if (rxv) m_rx(rxd);
    if (we && adr == 2'd2) begin
      m_en = dat[7];
      m_thr = dat[3:0];
    end
    @(posedge clk); #1;
    wb_stb = 1'b0; rx_valid = 1'b0;
    check("ack_timing", {7'b0, wb_ack}, 8'h01);
  endtask

  task automatic rx_byte(input logic [7:0] d);
    @(posedge clk); #1;
    rx_valid = 1'b1; rx_data = d;
    m_rx(d);
    @(posedge clk); #1;
    rx_valid = 1'b0;
  endtask

  task automatic check_irq();
    bit e;
    e = m_irq();
    @(posedge clk); #1;
    check("irq", {7'b0, irq}, {7'b0, e});
  endtask

  // Monitor: every ack pops one expectation; non-ack cycles must show zero data.
  initial begin
    logic [7:0] e;
    int a;
    logic prev_ack = 1'b0;
    forever begin
      @(negedge clk);
      if (wb_ack) begin
        check("ack_pulse", {7'b0, prev_ack}, 8'h00);
        if (exp_q.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_ack: got ack with data %02h, required no ack", wb_dat_o);
        end else begin
          e = exp_q.pop_front();
          a = adr_q.pop_front();
          check($sformatf("rd_adr%0d", a), wb_dat_o, e);
        end
      end else begin
        check("dat_idle", wb_dat_o, 8'h00);
      end
      prev_ack = wb_ack;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ei;
    repeat (3) @(posedge clk);
    #1;
    check("rst_ack", {7'b0, wb_ack}, 8'h00);
    check("rst_dat", wb_dat_o, 8'h00);
    check("rst_irq", {7'b0, irq}, 8'h00);
    rst = 1'b0;

    bus(0, 2'd1, 8'h00, 0, 8'h00);
    bus(0, 2'd0, 8'h00, 0, 8'h00);
    bus(0, 2'd1, 8'h00, 0, 8'h00);

    rx_byte(8'h41); rx_byte(8'h42); rx_byte(8'h43);
    bus(0, 2'd1, 8'h00, 0, 8'h00);
    repeat (3) bus(0, 2'd0, 8'h00, 0, 8'h00);
    bus(0, 2'd1, 8'h00, 0, 8'h00);

    for (int i = 0; i < 5; i++) rx_byte(8'h10 + 8'(i));
    bus(0, 2'd1, 8'h00, 0, 8'h00);
    repeat (4) bus(0, 2'd0, 8'h00, 0, 8'h00);
    bus(1, 2'd1, 8'h00, 0, 8'h00);
    bus(0, 2'd1, 8'h00, 0, 8'h00);

    for (int i = 1; i <= 4; i++) rx_byte(8'(i));
    bus(0, 2'd0, 8'h00, 1, 8'h05);
    bus(0, 2'd1, 8'h00, 0, 8'h00);
    repeat (4) bus(0, 2'd0, 8'h00, 0, 8'h00);

    bus(1, 2'd2, 8'h81, 0, 8'h00);
    bus(0, 2'd2, 8'h00, 0, 8'h00);
    rx_byte(8'h55); check_irq();
    rx_byte(8'h56); check_irq();
    bus(0, 2'd0, 8'h00, 0, 8'h00); check_irq();

    bus(1, 2'd2, 8'h8F, 0, 8'h00);
    rx_byte(8'h77);
    repeat (40) @(posedge clk);
    #1;
`ifdef UART_RX_CTRL_TIMEOUT_EN
    ei = 1'b1;
`else
    ei = m_irq();
`endif
    check("timeout_irq", {7'b0, irq}, {7'b0, ei});
    bus(0, 2'd0, 8'h00, 0, 8'h00); check_irq();
    bus(0, 2'd0, 8'h00, 0, 8'h00); check_irq();

    // Reset while a read is in flight: no ack, no pop, all state cleared.
    rx_byte(8'hAA); rx_byte(8'hBB);
    @(posedge clk); #1;
    wb_stb = 1'b1; wb_we = 1'b0; wb_adr = 2'd0;
    #3 rst = 1'b1;
    @(posedge clk); #1;
    check("rst_mid_ack", {7'b0, wb_ack}, 8'h00);
    check("rst_mid_dat", wb_dat_o, 8'h00);
    wb_stb = 1'b0;
    rst = 1'b0;
    m_q.delete(); m_ovr = 1'b0; m_en = 1'b0; m_thr = 4'h0;
    bus(0, 2'd1, 8'h00, 0, 8'h00);
    bus(0, 2'd2, 8'h00, 0, 8'h00);

    bus(1, 2'd2, 8'(8'h80 | $urandom_range(0, 5)), 0, 8'h00);
    for (int i = 0; i < 300; i++) begin
      case ($urandom_range(0, 9))
        0, 1, 2, 3: rx_byte(8'($urandom));
        4, 5:       bus(0, 2'd0, 8'h00, 0, 8'h00);
        6:          bus(0, 2'($urandom), 8'h00, 0, 8'h00);
        7:          bus(1, 2'($urandom), 8'($urandom), 0, 8'h00);
        8:          bus(0, 2'd0, 8'h00, 1, 8'($urandom));
        default:    if (irq_predictable()) check_irq();
      endcase
    end
    repeat (4) @(posedge clk);
    #1;
    check("drain", 8'(exp_q.size()), 8'h00);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
